// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-channel PM/DM memory.
package mem_pkg;

  localparam int unsigned DM_CH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DEFER = 1'b1
  } state_t;

  function automatic int unsigned bank_bits(input int unsigned n);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) b = i + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/dm_bank.sv
// One DM bank: single write port and a registered read port (read-before-write).
module dm_bank
  import mem_pkg::*;
#(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_pm_memory_v2.sv
// PM with read/write port plus banked two-channel DM with one-cycle conflict stall.
// Optional read-after-write forwarding is enabled by defining DM_BYPASS_EN.
module dm_pm_memory_v2
  import mem_pkg::*;
#(
  parameter int unsigned PMA_SIZE = 8,
  parameter int unsigned PMD_SIZE = 32,
  parameter int unsigned DMA_SIZE = 8,
  parameter int unsigned DMD_SIZE = 16,
  parameter int unsigned DM_BANKS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ps_pm_cslt,
  input  logic                      ps_pm_wrb,
  input  logic [PMA_SIZE-1:0]       ps_pm_add,
  input  logic [PMD_SIZE-1:0]       ps_pm_dt,
  output logic [PMD_SIZE-1:0]       pm_ps_op,
  input  logic [DM_CH-1:0]          ps_dm_cslt,
  input  logic [DM_CH-1:0]          ps_dm_wrb,
  input  logic [DM_CH*DMA_SIZE-1:0] dg_dm_add,
  input  logic [DM_CH*DMD_SIZE-1:0] bc_dt,
  output logic [DM_CH*DMD_SIZE-1:0] dm_bc_dt,
  output logic                      dm_ps_stall
);

  localparam int unsigned BW  = bank_bits(DM_BANKS);
  localparam int unsigned WAW = (DMA_SIZE > BW) ? DMA_SIZE - BW : 1;

  // ---------------- PM ----------------
  logic [PMD_SIZE-1:0] r_pm [2**PMA_SIZE];
  logic [PMD_SIZE-1:0] r_pm_op;

  always_ff @(posedge clk) begin
    if (ps_pm_cslt && ps_pm_wrb) r_pm[ps_pm_add] <= ps_pm_dt;
  end

  always_ff @(posedge clk) begin
    if (reset)                         r_pm_op <= '0;
    else if (ps_pm_cslt && !ps_pm_wrb) r_pm_op <= r_pm[ps_pm_add];
    else                               r_pm_op <= '0;
  end

  assign pm_ps_op = r_pm_op;

  // ---------------- DM ----------------
  logic [DM_CH-1:0][DMA_SIZE-1:0] w_add;
  logic [DM_CH-1:0][DMD_SIZE-1:0] w_bc;
  assign w_add = dg_dm_add;
  assign w_bc  = bc_dt;

  state_t              r_state;
  logic                r_stall;
  logic                r_def_wrb;
  logic [DMA_SIZE-1:0] r_def_addr;

  logic                           w_conflict;
  logic [DM_CH-1:0]               w_iss_vld;
  logic [DM_CH-1:0]               w_iss_wrb;
  logic [DM_CH-1:0][DMA_SIZE-1:0] w_iss_addr;
  logic [DM_CH-1:0][BW-1:0]       w_iss_bank;

  // In DEFER only the captured channel-1 request issues; live inputs are ignored.
  always_comb begin
    w_conflict = (r_state == IDLE) && ps_dm_cslt[0] && ps_dm_cslt[1] &&
                 (w_add[0][BW-1:0] == w_add[1][BW-1:0]);
    w_iss_vld[0]  = (r_state == IDLE) && ps_dm_cslt[0];
    w_iss_wrb[0]  = ps_dm_wrb[0];
    w_iss_addr[0] = w_add[0];
    if (r_state == DEFER) begin
      w_iss_vld[1]  = 1'b1;
      w_iss_wrb[1]  = r_def_wrb;
      w_iss_addr[1] = r_def_addr;
    end else begin
      w_iss_vld[1]  = ps_dm_cslt[1] && !w_conflict;
      w_iss_wrb[1]  = ps_dm_wrb[1];
      w_iss_addr[1] = w_add[1];
    end
    for (int unsigned c = 0; c < DM_CH; c++) begin
      w_iss_bank[c] = w_iss_addr[c][BW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_stall    <= 1'b0;
      r_def_wrb  <= 1'b0;
      r_def_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_conflict) begin
            r_state    <= DEFER;
            r_stall    <= 1'b1;
            r_def_wrb  <= ps_dm_wrb[1];
            r_def_addr <= w_add[1];
          end else begin
            r_stall <= 1'b0;
          end
        end
        DEFER: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign dm_ps_stall = r_stall;

  logic [DM_CH-1:0]               r_rd_vld;
  logic [DM_CH-1:0][BW-1:0]       r_rd_bank;
  logic [DM_CH-1:0]               r_pw_vld;
  logic [DM_CH-1:0][DMA_SIZE-1:0] r_pw_addr;
  logic [DM_CH-1:0][DMD_SIZE-1:0] r_dout;
  logic [DM_CH-1:0][DMD_SIZE-1:0] w_dout;
  logic [DMD_SIZE-1:0]            w_bank_q [DM_BANKS];

`ifdef DM_BYPASS_EN
  logic [DM_CH-1:0]               w_byp_hit;
  logic [DM_CH-1:0][DMD_SIZE-1:0] w_byp_data;
  logic [DM_CH-1:0]               r_byp_vld;
  logic [DM_CH-1:0][DMD_SIZE-1:0] r_byp_data;

  // Later channel overrides, so channel 1's pending data wins on a double match.
  always_comb begin
    w_byp_hit  = '0;
    w_byp_data = '0;
    for (int unsigned c = 0; c < DM_CH; c++) begin
      if (w_iss_vld[c] && !w_iss_wrb[c]) begin
        for (int unsigned k = 0; k < DM_CH; k++) begin
          if (r_pw_vld[k] && (r_pw_addr[k] == w_iss_addr[c])) begin
            w_byp_hit[c]  = 1'b1;
            w_byp_data[c] = w_bc[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byp_vld  <= '0;
      r_byp_data <= '0;
    end else begin
      r_byp_vld  <= w_byp_hit;
      r_byp_data <= w_byp_data;
    end
  end
`endif

  always_comb begin
    for (int unsigned c = 0; c < DM_CH; c++) begin
      w_dout[c] = r_dout[c];
      if (r_rd_vld[c]) begin
        w_dout[c] = w_bank_q[r_rd_bank[c]];
`ifdef DM_BYPASS_EN
        if (r_byp_vld[c]) w_dout[c] = r_byp_data[c];
`endif
      end
    end
  end

  assign dm_bc_dt = w_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld  <= '0;
      r_rd_bank <= '0;
      r_pw_vld  <= '0;
      r_pw_addr <= '0;
      r_dout    <= '0;
    end else begin
      for (int unsigned c = 0; c < DM_CH; c++) begin
        r_rd_vld[c]  <= w_iss_vld[c] && !w_iss_wrb[c];
        r_rd_bank[c] <= w_iss_bank[c];
        r_pw_vld[c]  <= w_iss_vld[c] && w_iss_wrb[c];
        r_pw_addr[c] <= w_iss_addr[c];
      end
      r_dout <= w_dout;
    end
  end

  for (genvar b = 0; b < DM_BANKS; b++) begin : g_bank
    logic                w_we;
    logic                w_re;
    logic [WAW-1:0]      w_wa;
    logic [WAW-1:0]      w_ra;
    logic [DMD_SIZE-1:0] w_wd;

    // Pending writes take bc_dt live during their data cycle; reset drops them.
    always_comb begin
      w_we = 1'b0;
      w_wa = '0;
      w_wd = '0;
      w_re = 1'b0;
      w_ra = '0;
      for (int unsigned c = 0; c < DM_CH; c++) begin
        if (r_pw_vld[c] && (r_pw_addr[c][BW-1:0] == BW'(b))) begin
          w_we = !reset;
          w_wa = WAW'(r_pw_addr[c] >> BW);
          w_wd = w_bc[c];
        end
        if (w_iss_vld[c] && !w_iss_wrb[c] && (w_iss_bank[c] == BW'(b))) begin
          w_re = 1'b1;
          w_ra = WAW'(w_iss_addr[c] >> BW);
        end
      end
    end

    dm_bank #(
      .AW(WAW),
      .DW(DMD_SIZE)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_wa),
      .i_wdata (w_wd),
      .i_re    (w_re),
      .i_raddr (w_ra),
      .o_rdata (w_bank_q[b])
    );
  end

endmodule

// File: tb/tb_dm_pm_memory_v2.sv
// Directed self-checking bench for dm_pm_memory_v2 (default parameters, DM_BANKS=2).
module tb_dm_pm_memory_v2;

  logic        clk;
  logic        reset;
  logic        ps_pm_cslt;
  logic        ps_pm_wrb;
  logic [7:0]  ps_pm_add;
  logic [31:0] ps_pm_dt;
  logic [31:0] pm_ps_op;
  logic [1:0]  ps_dm_cslt;
  logic [1:0]  ps_dm_wrb;
  logic [15:0] dg_dm_add;
  logic [31:0] bc_dt;
  logic [31:0] dm_bc_dt;
  logic        dm_ps_stall;

  int errors;
  int checks;

  dm_pm_memory_v2 #(
    .PMA_SIZE(8),
    .PMD_SIZE(32),
    .DMA_SIZE(8),
    .DMD_SIZE(16),
    .DM_BANKS(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps_pm_cslt  (ps_pm_cslt),
    .ps_pm_wrb   (ps_pm_wrb),
    .ps_pm_add   (ps_pm_add),
    .ps_pm_dt    (ps_pm_dt),
    .pm_ps_op    (pm_ps_op),
    .ps_dm_cslt  (ps_dm_cslt),
    .ps_dm_wrb   (ps_dm_wrb),
    .dg_dm_add   (dg_dm_add),
    .bc_dt       (bc_dt),
    .dm_bc_dt    (dm_bc_dt),
    .dm_ps_stall (dm_ps_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs set and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic cs, input logic wr,
                        input logic [7:0] addr, input logic [15:0] data);
    ps_dm_cslt[ch]          = cs;
    ps_dm_wrb[ch]           = wr;
    dg_dm_add[ch*8 +: 8]    = addr;
    bc_dt[ch*16 +: 16]      = data;
  endtask

  // Single-channel write: issue, then hold data through the sampling cycle.
  task automatic dm_write(input int ch, input logic [7:0] addr, input logic [15:0] data);
    set_ch(ch, 1'b1, 1'b1, addr, data);
    tick();
    ps_dm_cslt[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (pm_ps_op !== 32'h0) begin
      errors++; $display("FAIL reset_pm: got %h want %h", pm_ps_op, 32'h0);
    end
    checks++;
    if (dm_bc_dt !== 32'h0) begin
      errors++; $display("FAIL reset_dm: got %h want %h", dm_bc_dt, 32'h0);
    end
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", dm_ps_stall);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pm();
    ps_pm_cslt = 1'b1; ps_pm_wrb = 1'b1; ps_pm_add = 8'd5; ps_pm_dt = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (pm_ps_op !== 32'h0) begin
      errors++; $display("FAIL pm_write_op: got %h want %h", pm_ps_op, 32'h0);
    end
    ps_pm_add = 8'd6; ps_pm_dt = 32'h1234_5678;
    tick();
    ps_pm_wrb = 1'b0; ps_pm_add = 8'd5;
    tick();
    checks++;
    if (pm_ps_op !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pm_read5: got %h want %h", pm_ps_op, 32'hDEAD_BEEF);
    end
    ps_pm_add = 8'd6;
    tick();
    checks++;
    if (pm_ps_op !== 32'h1234_5678) begin
      errors++; $display("FAIL pm_read6: got %h want %h", pm_ps_op, 32'h1234_5678);
    end
    ps_pm_cslt = 1'b0;
    tick();
    checks++;
    if (pm_ps_op !== 32'h0) begin
      errors++; $display("FAIL pm_desel: got %h want %h", pm_ps_op, 32'h0);
    end
  endtask

  task automatic test_no_conflict();
    set_ch(0, 1'b1, 1'b1, 8'd4, 16'h1234);
    set_ch(1, 1'b1, 1'b1, 8'd7, 16'h5678);
    tick();
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL nc_wr_stall: got %b want 0", dm_ps_stall);
    end
    ps_dm_cslt = 2'b00;
    tick();
    set_ch(0, 1'b1, 1'b0, 8'd4, 16'h0000);
    set_ch(1, 1'b1, 1'b0, 8'd7, 16'h0000);
    tick();
    checks++;
    if (dm_bc_dt !== 32'h5678_1234) begin
      errors++; $display("FAIL nc_read: got %h want %h", dm_bc_dt, 32'h5678_1234);
    end
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL nc_rd_stall: got %b want 0", dm_ps_stall);
    end
    // Deselect ch1 and let ch0 write: neither output slice may change.
    set_ch(0, 1'b1, 1'b1, 8'd20, 16'hBEEF);
    ps_dm_cslt[1] = 1'b0;
    tick();
    ps_dm_cslt = 2'b00;
    tick();
    checks++;
    if (dm_bc_dt !== 32'h5678_1234) begin
      errors++; $display("FAIL nc_hold: got %h want %h", dm_bc_dt, 32'h5678_1234);
    end
  endtask

  task automatic test_conflict_read();
    dm_write(0, 8'd2, 16'h0202);
    dm_write(1, 8'd6, 16'h0606);
    set_ch(0, 1'b1, 1'b0, 8'd2, 16'h0000);
    set_ch(1, 1'b1, 1'b0, 8'd6, 16'h0000);
    tick();
    checks++;
    if (dm_ps_stall !== 1'b1) begin
      errors++; $display("FAIL cr_stall_n1: got %b want 1", dm_ps_stall);
    end
    checks++;
    if (dm_bc_dt[15:0] !== 16'h0202) begin
      errors++; $display("FAIL cr_ch0_n1: got %h want %h", dm_bc_dt[15:0], 16'h0202);
    end
    tick();
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL cr_stall_n2: got %b want 0", dm_ps_stall);
    end
    checks++;
    if (dm_bc_dt !== 32'h0606_0202) begin
      errors++; $display("FAIL cr_both_n2: got %h want %h", dm_bc_dt, 32'h0606_0202);
    end
    ps_dm_cslt = 2'b00;
    tick();
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL cr_stall_n3: got %b want 0", dm_ps_stall);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_first;
`ifdef DM_BYPASS_EN
    exp_first = 16'hFFEE;
`else
    exp_first = 16'h0303;
`endif
    dm_write(0, 8'd3, 16'h0303);
    set_ch(0, 1'b1, 1'b1, 8'd3, 16'hFFEE);
    tick();
    ps_dm_cslt[0] = 1'b0;
    set_ch(1, 1'b1, 1'b0, 8'd3, 16'h0000);
    tick();
    checks++;
    if (dm_bc_dt[31:16] !== exp_first) begin
      errors++; $display("FAIL byp_first: got %h want %h", dm_bc_dt[31:16], exp_first);
    end
    bc_dt[15:0] = 16'h0000;
    tick();
    checks++;
    if (dm_bc_dt[31:16] !== 16'hFFEE) begin
      errors++; $display("FAIL byp_second: got %h want %h", dm_bc_dt[31:16], 16'hFFEE);
    end
    ps_dm_cslt = 2'b00;
    tick();
  endtask

  task automatic test_ww_conflict();
    set_ch(0, 1'b1, 1'b1, 8'd9, 16'hAAAA);
    set_ch(1, 1'b1, 1'b1, 8'd9, 16'h5555);
    tick();
    checks++;
    if (dm_ps_stall !== 1'b1) begin
      errors++; $display("FAIL ww_stall_n1: got %b want 1", dm_ps_stall);
    end
    tick();
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL ww_stall_n2: got %b want 0", dm_ps_stall);
    end
    ps_dm_cslt = 2'b00;
    tick();
    set_ch(0, 1'b1, 1'b0, 8'd9, 16'h0000);
    tick();
    checks++;
    if (dm_bc_dt[15:0] !== 16'h5555) begin
      errors++; $display("FAIL ww_final: got %h want %h", dm_bc_dt[15:0], 16'h5555);
    end
    ps_dm_cslt = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    set_ch(0, 1'b1, 1'b0, 8'd4, 16'h0000);
    set_ch(1, 1'b1, 1'b0, 8'd7, 16'h0000);
    tick();
    set_ch(0, 1'b1, 1'b0, 8'd2, 16'h0000);
    set_ch(1, 1'b1, 1'b0, 8'd9, 16'h0000);
    checks++;
    if (dm_bc_dt !== 32'h5678_1234) begin
      errors++; $display("FAIL b2b_first: got %h want %h", dm_bc_dt, 32'h5678_1234);
    end
    tick();
    checks++;
    if (dm_bc_dt !== 32'h5555_0202) begin
      errors++; $display("FAIL b2b_second: got %h want %h", dm_bc_dt, 32'h5555_0202);
    end
    ps_dm_cslt = 2'b00;
    tick();
  endtask

  task automatic test_reset_defer();
    dm_write(0, 8'd10, 16'h0A0A);
    dm_write(1, 8'd12, 16'h0C0C);
    set_ch(0, 1'b1, 1'b1, 8'd10, 16'h1111);
    set_ch(1, 1'b1, 1'b1, 8'd12, 16'h2222);
    tick();
    checks++;
    if (dm_ps_stall !== 1'b1) begin
      errors++; $display("FAIL rd_stall_n1: got %b want 1", dm_ps_stall);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dm_ps_stall !== 1'b0) begin
      errors++; $display("FAIL rd_stall_n2: got %b want 0", dm_ps_stall);
    end
    checks++;
    if (dm_bc_dt !== 32'h0) begin
      errors++; $display("FAIL rd_dm_n2: got %h want %h", dm_bc_dt, 32'h0);
    end
    checks++;
    if (pm_ps_op !== 32'h0) begin
      errors++; $display("FAIL rd_pm_n2: got %h want %h", pm_ps_op, 32'h0);
    end
    reset = 1'b0;
    ps_dm_cslt = 2'b00;
    tick();
    tick();
    set_ch(1, 1'b1, 1'b0, 8'd12, 16'h0000);
    tick();
    checks++;
    if (dm_bc_dt[31:16] !== 16'h0C0C) begin
      errors++; $display("FAIL rd_not_written: got %h want %h", dm_bc_dt[31:16], 16'h0C0C);
    end
    ps_dm_cslt = 2'b00;
    tick();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    ps_pm_cslt = 1'b0;
    ps_pm_wrb  = 1'b0;
    ps_pm_add  = '0;
    ps_pm_dt   = '0;
    ps_dm_cslt = '0;
    ps_dm_wrb  = '0;
    dg_dm_add  = '0;
    bc_dt      = '0;
    #1;
    test_reset();
    test_pm();
    test_no_conflict();
    test_conflict_read();
    test_bypass();
    test_ww_conflict();
    test_back_to_back();
    test_reset_defer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_pm_memory_v2.md
# dm_pm_memory_v2

Dual-channel program/data memory for the core, successor to the single-port PM/DM memory. PM gains a write port for `PM(I,M)=ureg`. DM is split into `DM_BANKS` low-order-interleaved banks serving two data-address-generator channels per cycle. Same-bank collisions are resolved with a one-cycle stall to the program sequencer. It sits between the program sequencer (PM), the DAGs (DM addresses) and the bus connect (DM data).

## Interface
Parameters:
- `PMA_SIZE`, default 8: PM address width.
- `PMD_SIZE`, default 32: PM word width.
- `DMA_SIZE`, default 8: DM address width.
- `DMD_SIZE`, default 16: DM word width.
- `DM_BANKS`, default 2: DM bank count. Must be a power of two, ≥2 and ≤2**DMA_SIZE.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `ps_pm_cslt` in 1: PM chip select.
- `ps_pm_wrb` in 1: PM write (1) / read (0).
- `ps_pm_add` in PMA_SIZE: PM address.
- `ps_pm_dt` in PMD_SIZE: PM write data.
- `pm_ps_op` out PMD_SIZE: PM read data.
- `ps_dm_cslt` in 2: DM select, bit c = channel c.
- `ps_dm_wrb` in 2: DM write (1) / read (0) per channel.
- `dg_dm_add` in 2*DMA_SIZE: channel c address at `[c*DMA_SIZE +: DMA_SIZE]`.
- `bc_dt` in 2*DMD_SIZE: channel c write data, sliced the same way.
- `dm_bc_dt` out 2*DMD_SIZE: channel c read data.
- `dm_ps_stall` out 1: bank-conflict stall to the sequencer.

## Operation
- Bank index = `add[BW-1:0]` with BW = log2(DM_BANKS). Bank word address = `add[DMA_SIZE-1:BW]`.
- **PM:**
  - `cslt & ~wrb`: `pm_ps_op <= pm[add]`.
  - `cslt & wrb`: `pm[add] <= ps_pm_dt` and `pm_ps_op <= 0`.
  - `~cslt`: `pm_ps_op <= 0`.
- **DM request issue:** a channel's request is issued in the cycle it is accepted.
  - Reads return data registered from the bank.
  - Writes latch the address at issue. Data is sampled from `bc_dt` in the following cycle (execute+1), and the bank is written at the end of that cycle.
- **Conflict:** both channels selected in the same bank (any read/write mix, including identical addresses).
  - Channel 0 issues; channel 1 is captured in a deferral register.
  - FSM IDLE→DEFER, and `dm_ps_stall`=1 for exactly one cycle.
  - In DEFER, channel 1 is issued from the deferral register and the live inputs are ignored. The core holds all inputs, including `bc_dt[1]`, while stalled.
  - FSM DEFER→IDLE unconditionally.
- **No conflict:** both channels issue in the same cycle; FSM stays IDLE.
- **Write-write to the same address:** channel 1 lands last and wins.
- **Pending writes:** at most one per bank per cycle, guaranteed by conflict handling.
- **Unselected channel:** `dm_bc_dt` slice holds its last value; writes do not change it.
- **Reset:**
  - `pm_ps_op`=0, `dm_bc_dt`=0, `dm_ps_stall`=0, FSM=IDLE.
  - The deferred request and pending writes are discarded.
  - Array contents are not reset.

## Timing
- PM read latency: 1 cycle. Address at cycle N, data valid in cycle N+1. A write at N is visible to a read issued at N+1.
- DM read latency, no conflict: address at N, data in N+1.
- On conflict at N:
  - `dm_ps_stall` is high in N+1.
  - Channel 0 data is valid in N+1 and held through N+2.
  - Channel 1 data is valid in N+2.
- DM write: issued at N, data sampled in N+1, array updated at the N+1→N+2 edge. A deferred channel-1 write samples `bc_dt[1]` in N+2.
- Reset asserted during DEFER: the next cycle is IDLE with stall 0, and the deferred access is never performed.

## Configuration
- `DM_BYPASS_EN` defined: a read issued in the cycle a pending write to the same address is sampling data returns the current `bc_dt` of that write. If both channels' pending writes match, channel 1's data is returned.
- `DM_BYPASS_EN` undefined: such a read returns the pre-write array contents, with no forwarding logic.

## Structure
- **Package `mem_pkg`:**
  - FSM enum `{IDLE, DEFER}`.
  - Function `bank_bits(DM_BANKS)`.
  - Channel-count constant `DM_CH = 2`.
- **Sub-module `dm_bank`:**
  - One bank RAM with a registered read port and one write port (address + enable + data).
  - Instantiated DM_BANKS times via generate.
  - The top contains routing, the conflict FSM, write latching and bypass.

## Test plan
1. PM write `ps_pm_add=5`, `ps_pm_dt=32'hDEAD_BEEF`, then read at 5 next cycle → `pm_ps_op=32'hDEAD_BEEF` one cycle after the read. With `~cslt` → 0.
2. Channel 0 write addr 4, data `16'h1234`, plus channel 1 write addr 7 (different bank) in the same cycle. Then read both → `16'h1234` and channel 1's data in the next cycle, no stall.
3. Both channels read addrs 2 and 6 (bank 0, DM_BANKS=2) at N → stall high only in N+1, `dm_bc_dt[0]=mem[2]` in N+1, `dm_bc_dt[1]=mem[6]` in N+2.
4. Channel 0 write addr 3 with `bc_dt=16'hFFEE`, then channel 1 reads addr 3 next cycle → with `DM_BYPASS_EN`, `16'hFFEE`; without it, the old value. One cycle later the read gives `16'hFFEE` in both builds.
5. Both channels write addr 9 (data `16'hAAAA` and `16'h5555`) → stall 1 cycle, final `mem[9]=16'h5555`.
6. Conflict at N, `reset` high in N+1 → outputs 0 at N+2, stall 0, and the deferred channel 1 write is not performed.
